// File: rtl/diff_pkg.sv
// diff_pkg: shared types and sizing helpers for the DIFF sequencer.
//   No ports; provides state_e, DIFF_WIDTH and cnt_w().
package diff_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  localparam int DIFF_WIDTH = 32;
  function automatic int cnt_w(input int width, input int chunk);
    return (width / chunk > 1) ? $clog2(width / chunk) : 1;
  endfunction
endpackage

// File: rtl/lsb_pick.sv
// lsb_pick: combinational lowest-set-bit encoder for one CHUNK-bit slice.
//   vec   - slice to search
//   valid - slice has at least one set bit
//   idx   - position of the lowest set bit (0 when none)
module lsb_pick #(
  parameter int CHUNK = 4,
  localparam int IW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] vec,
  output logic             valid,
  output logic [IW-1:0]    idx
);
  assign valid = |vec;
  always_comb begin
    idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/diff_ctrl.sv
// diff_ctrl: multi-cycle DIFF sequencer; finds the lowest differing bit of two operands.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, abort - request (taken in IDLE) and pipeline flush
//   in1, in2     - operands, sampled on the accepting edge
//   busy, done   - operation in progress, one-cycle result-valid pulse
//   out, ifequal - lowest differing bit index (0 if equal), equality flag
module diff_ctrl
  import diff_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  output logic                  busy,
  output logic                  done,
  output logic [DIFF_WIDTH-1:0] out,
  output logic                  ifequal
);
  localparam int NC = WIDTH / CHUNK;
  localparam int CW = cnt_w(WIDTH, CHUNK);
  localparam int OW = $clog2(WIDTH);
  localparam int IW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  state_e                state_q, state_d;
  logic [WIDTH-1:0]      xor_q, xor_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIFF_WIDTH-1:0] out_q, out_d;
  logic                  ifequal_q, ifequal_d, busy_q, done_q;
  logic [WIDTH-1:0]      xor_in;
  logic [CHUNK-1:0]      slice;
  logic                  valid;
  logic [IW-1:0]         idx;
  logic [OW-1:0]         pos;
  assign xor_in = in1 ^ in2;
  // Chunk 0 is resolved straight from the operands in IDLE, so SCAN starts at
  // chunk 1 and a first difference at bit i completes in floor(i/CHUNK)+1 cycles.
  assign slice = (state_q == IDLE) ? xor_in[CHUNK-1:0] : xor_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign pos = OW'(((state_q == IDLE) ? 0 : int'(cnt_q)) * CHUNK + int'(idx));
  lsb_pick #(.CHUNK(CHUNK)) u_pick (.vec(slice), .valid(valid), .idx(idx));
  always_comb begin
    state_d   = state_q;
    xor_d     = xor_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    ifequal_d = ifequal_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        if (xor_in == '0) begin
          state_d   = DONE;
          out_d     = '0;
          ifequal_d = 1'b1;
        end else if (valid) begin
          state_d   = DONE;
          out_d     = DIFF_WIDTH'(pos);
          ifequal_d = 1'b0;
        end else begin
          state_d = SCAN;
          xor_d   = xor_in;
          cnt_d   = CW'(1);
        end
      end
      SCAN: if (valid) begin
        state_d   = DONE;
        out_d     = DIFF_WIDTH'(pos);
        ifequal_d = 1'b0;
      end else if (cnt_q == CW'(NC - 1)) begin
        // Unreachable with a nonzero xor_q; kept so the FSM can never run away.
        state_d   = DONE;
        out_d     = '0;
        ifequal_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xor_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      ifequal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xor_q     <= xor_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      ifequal_q <= ifequal_d;
      busy_q    <= state_d != IDLE;
      done_q    <= state_d == DONE;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign out     = out_q;
  assign ifequal = ifequal_q;
endmodule

// File: tb/tb_diff_ctrl.sv
// tb_diff_ctrl: self-checking bench for diff_ctrl (vectors, corner sequences, random vs model).
module tb_diff_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [31:0] in1, in2, out;
  logic        busy, done, ifequal;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_eq;
    int          exp_lat;
  } vec_t;
  vec_t vecs[6];
  diff_ctrl dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in1(in1), .in2(in2),
                 .busy(busy), .done(done), .out(out), .ifequal(ifequal));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic e, output int lat);
    logic [31:0] x;
    x   = a ^ b;
    o   = 0;
    e   = (x == 0);
    lat = 1;
    for (int i = 31; i >= 0; i--) if (x[i]) begin
      o   = i;
      lat = i / 4 + 1;
    end
  endfunction
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ee, input int el);
    int cyc;
    accept(a, b);
    chk({name, "_busy"}, busy, 1);
    cyc = 1;
    while (!done && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_lat"}, cyc, el);
    chk({name, "_out"}, out, eo);
    chk({name, "_eq"}, ifequal, ee);
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, done, 0);
    chk({name, "_idle"}, busy, 0);
  endtask
  initial begin
    int          cyc, extra;
    logic [31:0] a, b, eo;
    logic        ee;
    int          el;
    vecs[0] = '{32'h5, 32'h5, 0, 1'b1, 1};
    vecs[1] = '{32'h0, 32'h1, 0, 1'b0, 1};
    vecs[2] = '{32'hF0, 32'h30, 6, 1'b0, 2};
    vecs[3] = '{32'h0, 32'h8000_0000, 31, 1'b0, 8};
    vecs[4] = '{32'h0, 32'h10, 4, 1'b0, 2};
    vecs[5] = '{32'h1, 32'h3, 1, 1'b0, 1};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in1   = 0;
    in2   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_eq", ifequal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_eq, vecs[i].exp_lat);
    // start pulsed mid-scan must be ignored and yield no second done
    accept(32'h0, 32'h8000_0000);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    in1   = 32'h5;
    in2   = 32'h5;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 4;
    while (!done && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ign_lat", cyc, 8);
    chk("ign_out", out, 31);
    chk("ign_eq", ifequal, 0);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("ign_no_second_done", extra, 0);
    // abort in cycle 4 returns to IDLE with out still 31
    accept(32'h0, 32'h8000_0000);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 31);
    extra = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    run_op("post_abort", 32'h0, 32'h10, 4, 1'b0, 2);
    // asynchronous reset mid-scan
    accept(32'h0, 32'h8000_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_out", out, 0);
    chk("mrst_eq", ifequal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h1, 32'h3, 1, 1'b0, 1);
    // random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : a ^ ($urandom << $urandom_range(0, 31));
      if (a == b && i % 7 == 3) b = a ^ 32'h1;
      ref_model(a, b, eo, ee, el);
      run_op($sformatf("rnd%0d", i), a, b, eo, ee, el);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
